// File: rtl/run_controller_if.sv
// Run-control bundle between the run controller, its upstream driver and the core.
// The master side drives start/limit/core status and the slave side returns sequencing status.
interface run_controller_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [CNT_W-1:0] run_limit;
  logic             halt;
  logic             instr_retire;
  logic             dump_ack;
  logic             cpu_reset;
  logic             running;
  logic             dump_req;
  logic             complete;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output start, run_limit, halt, instr_retire, dump_ack,
    input  cpu_reset, running, dump_req, complete, timeout, cycle_count, retire_count
  );

  modport slave (
    input  start, run_limit, halt, instr_retire, dump_ack,
    output cpu_reset, running, dump_req, complete, timeout, cycle_count, retire_count
  );
endinterface

// File: rtl/run_controller.sv
// Run controller: sequences core reset, counts RUN cycles, stops on halt or limit, drains, dumps.
// Define RUN_CTRL_RETIRE_CNT_EN to enable the retired-instruction counter.
module run_controller #(
  parameter int RESET_CYCLES = 4,
  parameter int DRAIN_CYCLES = 8,
  parameter int CNT_W        = 32
) (
  input logic           clk,
  input logic           reset,
  run_controller_if.slave bus
);

  localparam int PHASE_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
  localparam int PW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam logic [PW-1:0] HOLD_LAST  = PW'(RESET_CYCLES - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RST_HOLD, RUN, DRAIN, DUMP, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [PW-1:0]    phase;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] retire_q;
  logic             timeout_q;
  logic             start_ok;
  logic             limit_hit;

  assign start_ok  = bus.start && (state == IDLE || state == DONE);
  assign limit_hit = (limit_q != '0) && (cycle_q == limit_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (bus.start) state_next = RST_HOLD;
      RST_HOLD:   if (phase == HOLD_LAST) state_next = RUN;
      RUN:        if (bus.halt || limit_hit) state_next = DRAIN;
      DRAIN:      if (phase == DRAIN_LAST) state_next = DUMP;
      DUMP:       if (bus.dump_ack) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_reset = 1'b1;
    bus.running   = 1'b0;
    bus.dump_req  = 1'b0;
    bus.complete  = 1'b0;
    case (state)
      RUN: begin
        bus.cpu_reset = 1'b0;
        bus.running   = 1'b1;
      end
      DRAIN: bus.cpu_reset = 1'b0;
      DUMP: begin
        bus.cpu_reset = 1'b0;
        bus.dump_req  = 1'b1;
      end
      DONE:    bus.complete = 1'b1;
      default: ;
    endcase
  end

  // Shared dwell counter for RST_HOLD and DRAIN; restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset || state_next != state) phase <= '0;
    else if (state == RST_HOLD || state == DRAIN) phase <= phase + PW'(1);
  end

  // The RUN cycle that triggers the exit still counts, so a limit stop ends at cycle_count == limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      limit_q   <= '0;
      cycle_q   <= '0;
      timeout_q <= 1'b0;
    end else if (start_ok) begin
      limit_q   <= bus.run_limit;
      cycle_q   <= '0;
      timeout_q <= 1'b0;
    end else if (state == RUN) begin
      if (cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
      if (!bus.halt && limit_hit) timeout_q <= 1'b1;
    end
  end

`ifdef RUN_CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) retire_q <= '0;
    else if ((state == RUN || state == DRAIN) && bus.instr_retire && retire_q != '1)
      retire_q <= retire_q + CNT_W'(1);
  end
`else
  logic unused_retire;
  assign unused_retire = bus.instr_retire;
  assign retire_q      = '0;
`endif

  assign bus.timeout      = timeout_q;
  assign bus.cycle_count  = cycle_q;
  assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_run_controller.sv
// Randomized bench for run_controller: each run's timeline (hold, run, drain, dump, done)
// is predicted arithmetically from limit, halt cycle and ack delay.
module tb_run_controller;
  localparam int RC = 4;
  localparam int DC = 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vector_count = 0;
  int miss_count = 0;
  logic [CW-1:0] exp_retire = '0;

`ifdef RUN_CTRL_RETIRE_CNT_EN
  localparam bit RETIRE_EN = 1'b1;
`else
  localparam bit RETIRE_EN = 1'b0;
`endif

  run_controller_if #(.CNT_W(CW)) bus ();

  run_controller #(.RESET_CYCLES(RC), .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [CW-1:0] observed, input logic [CW-1:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string ph, input bit cr, input bit run, input bit dreq, input bit comp,
                          input bit tmo, input int cc, input logic [CW-1:0] rc);
    checkOutput({ph, ".cpu_reset"},    CW'(bus.cpu_reset), CW'(cr));
    checkOutput({ph, ".running"},      CW'(bus.running),   CW'(run));
    checkOutput({ph, ".dump_req"},     CW'(bus.dump_req),  CW'(dreq));
    checkOutput({ph, ".complete"},     CW'(bus.complete),  CW'(comp));
    checkOutput({ph, ".timeout"},      CW'(bus.timeout),   CW'(tmo));
    checkOutput({ph, ".cycle_count"},  bus.cycle_count,    CW'(cc));
    checkOutput({ph, ".retire_count"}, bus.retire_count,   rc);
  endtask

  // One run from IDLE/DONE; abort_at > 0 asserts reset after that many RUN cycles.
  task automatic applyStimulus(input int limit, input int halt_at, input int ack_delay, input int abort_at);
    int n;
    bit tmo;
    int last;
    int ph;
    bit ret;
    if (halt_at != 0 && (limit == 0 || halt_at <= limit)) begin
      n = halt_at;
      tmo = 1'b0;
    end else begin
      n = limit;
      tmo = 1'b1;
    end
    last = RC + n + DC + ack_delay + 1;
    bus.start = 1'b1;
    bus.run_limit = CW'(limit);
    bus.halt = 1'($urandom);
    bus.dump_ack = 1'($urandom);
    bus.instr_retire = 1'($urandom);
    exp_retire = '0;
    for (int e = 0; e <= last; e++) begin
      @(negedge clk);
      if (e < RC) ph = 0;
      else if (e < RC + n) ph = 1;
      else if (e < RC + n + DC) ph = 2;
      else if (e < last) ph = 3;
      else ph = 4;
      case (ph)
        0: checkAll("hold",  1, 0, 0, 0, 0,   0,      exp_retire);
        1: checkAll("run",   0, 1, 0, 0, 0,   e - RC, exp_retire);
        2: checkAll("drain", 0, 0, 0, 0, tmo, n,      exp_retire);
        3: checkAll("dump",  0, 0, 1, 0, tmo, n,      exp_retire);
        default: checkAll("done", 1, 0, 0, 1, tmo, n, exp_retire);
      endcase
      if (abort_at > 0 && ph == 1 && e == RC + abort_at) begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.halt = 1'($urandom);
        bus.instr_retire = 1'($urandom);
        @(negedge clk);
        checkAll("abort", 1, 0, 0, 0, 0, 0, '0);
        reset = 1'b0;
        exp_retire = '0;
        return;
      end
      bus.start = (e == last) ? 1'b0 : 1'($urandom);
      bus.run_limit = CW'($urandom);
      bus.halt = (ph == 1) ? (e - RC + 1 == halt_at) : 1'($urandom);
      bus.dump_ack = (ph == 3) ? (e - (RC + n + DC) == ack_delay) : 1'($urandom);
      ret = 1'($urandom);
      bus.instr_retire = ret;
      if (RETIRE_EN && ret && (ph == 1 || ph == 2)) exp_retire = exp_retire + CW'(1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkAll("idle_done", 1, 0, 0, 1, tmo, n, exp_retire);
      bus.halt = 1'($urandom);
      bus.dump_ack = 1'($urandom);
      bus.instr_retire = 1'($urandom);
    end
  endtask

  initial begin
    int lim;
    int hlt;
    bus.start = 1'b0;
    bus.run_limit = '0;
    bus.halt = 1'b0;
    bus.instr_retire = 1'b0;
    bus.dump_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkAll("reset", 1, 0, 0, 0, 0, 0, '0);
    reset = 1'b0;
    bus.halt = 1'b1;
    bus.dump_ack = 1'b1;
    bus.instr_retire = 1'b1;
    @(negedge clk);
    checkAll("idle", 1, 0, 0, 0, 0, 0, '0);
    applyStimulus(0, 10, 1, 0);
    applyStimulus(20, 0, 0, 0);
    applyStimulus(20, 20, 2, 0);
    applyStimulus(0, 6, 5, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(0, 15, 0, 7);
    applyStimulus(20, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      lim = $urandom_range(0, 25);
      hlt = $urandom_range(0, 25);
      if (lim == 0 && hlt == 0) hlt = 1;
      applyStimulus(lim, hlt, $urandom_range(0, 6), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end
endmodule
